// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and instruction memory.
// The fetch controller drives the request and the word address, and memory returns the instruction word with an acknowledge.
interface if_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller that loads the IF/ID register from instruction memory.
// It uses a one-entry skid buffer while decode is stalled and drops fetches that a redirect has killed.
module if_fetch_ctrl #(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           PC,
    input  logic                  flush,
    input  logic                  stall_id,
    if_fetch_ctrl_if.master       imem,
    output logic                  pc_adv,
    output logic [31:0]           IFID_Instr,
    output logic [31:0]           IFID_PCplus4,
    output logic                  IFID_Valid,
    output logic                  fetch_err
);

    localparam int             TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  T_ARM  = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    // Kernel bit is preserved; the increment wraps inside bits [30:0].
    function automatic logic [31:0] pc_plus4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    state_t        state_reg;
    logic [31:0]   fetch_pc_reg;
    logic          drop_reg;
    logic [31:0]   skid_instr_reg;
    logic [31:0]   skid_pc_reg;
    logic [TW-1:0] timer_reg;
    logic          fetch_err_reg;
    logic [31:0]   ifid_instr_reg;
    logic [31:0]   ifid_pcplus4_reg;
    logic          ifid_valid_reg;

    logic ifid_free;
    logic fetch_load;
    logic skid_load;

    assign ifid_free  = !stall_id || !ifid_valid_reg;
    assign fetch_load = (state_reg == WAIT) && imem.imem_ack && !drop_reg && !flush && ifid_free;
    assign skid_load  = (state_reg == HOLD) && !flush && !stall_id;
    assign pc_adv     = reset && (fetch_load || skid_load);

    assign imem.imem_req  = (state_reg == WAIT);
    assign imem.imem_addr = {fetch_pc_reg[31:2], 2'b00};

    assign IFID_Instr   = ifid_instr_reg;
    assign IFID_PCplus4 = ifid_pcplus4_reg;
    assign IFID_Valid   = ifid_valid_reg;
    assign fetch_err    = fetch_err_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            fetch_pc_reg     <= 32'h8000_0000;
            drop_reg         <= 1'b0;
            skid_instr_reg   <= NOP_INSTR;
            skid_pc_reg      <= 32'h8000_0000;
            timer_reg        <= '0;
            fetch_err_reg    <= 1'b0;
            ifid_instr_reg   <= NOP_INSTR;
            ifid_pcplus4_reg <= 32'h8000_0000;
            ifid_valid_reg   <= 1'b0;
        end else begin
            fetch_err_reg <= 1'b0;

            // A stalled valid IF/ID register holds its contents. Otherwise it either loads a new instruction or turns into a bubble.
            if (flush) begin
                ifid_instr_reg <= NOP_INSTR;
                ifid_valid_reg <= 1'b0;
            end else if (!(stall_id && ifid_valid_reg)) begin
                if (fetch_load) begin
                    ifid_instr_reg   <= imem.imem_rdata;
                    ifid_pcplus4_reg <= pc_plus4(fetch_pc_reg);
                    ifid_valid_reg   <= 1'b1;
                end else if (skid_load) begin
                    ifid_instr_reg   <= skid_instr_reg;
                    ifid_pcplus4_reg <= pc_plus4(skid_pc_reg);
                    ifid_valid_reg   <= 1'b1;
                end else begin
                    ifid_valid_reg <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    state_reg    <= WAIT;
                    fetch_pc_reg <= PC;
                    timer_reg    <= '0;
                end
                WAIT: begin
                    if (imem.imem_ack) begin
                        timer_reg <= '0;
                        if (drop_reg || flush) begin
                            drop_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else if (ifid_free) begin
                            fetch_pc_reg <= pc_plus4(PC);
                        end else begin
                            skid_instr_reg <= imem.imem_rdata;
                            skid_pc_reg    <= fetch_pc_reg;
                            state_reg      <= HOLD;
                        end
                    end else begin
                        // A request that has been issued cannot be withdrawn, so a redirect marks the data that comes back as stale.
                        if (flush) begin
                            drop_reg <= 1'b1;
                        end
                        if (timer_reg != T_LAST) begin
                            timer_reg <= timer_reg + 1'b1;
                        end
                        if (timer_reg == T_ARM) begin
                            fetch_err_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (flush || !stall_id) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
